// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory subsystem: region codes, MMIO map,
// register bit positions and the byte-lane merge helper.
package dmem_pkg;

  localparam logic [3:0] REGION_RAM  = 4'h0;
  localparam logic [3:0] REGION_MMIO = 4'h1;

  localparam logic [2:0] OFF_GPIO   = 3'd0;
  localparam logic [2:0] OFF_CTRL   = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  localparam int CTRL_TIMER_EN  = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int STATUS_MATCH   = 0;
  localparam int STATUS_BUS_ERR = 1;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_MMIO = 2'd2
  } sel_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// Single-port synchronous data RAM with per-byte write enables; read-first, so a
// same-address read during a write returns the pre-write word.
module dmem_ram_bank #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  input  logic [3:0]                     be_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes and registered read of the old word.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_mmio_ctrl.sv
// Data-memory port terminator: decodes RAM / MMIO / unmapped, holds the GPIO and
// timer registers, and returns read data one cycle after the address.
module dmem_mmio_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] dmaddr_in,
  input  logic [31:0] dmdata_in,
  input  logic [3:0]  dmwr_mask_in,
  input  logic        dmwr_req_in,
  output logic [31:0] dmdata_out,
  output logic [31:0] gpio_out,
  output logic        timer_irq_out,
  output logic        bus_err_out
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  logic        wr_s, is_ram_s, is_mmio_s;
  logic [2:0]  mmio_off_s;
  logic [3:0]  ram_be_s;
  logic [31:0] ram_rdata_s, mmio_rd_s;
  logic        unused_addr_s;
  sel_e        sel_d, sel_q;

  logic [31:0] gpio_d, gpio_q, count_d, count_q, cmp_d, cmp_q, mmio_rdata_q;
  logic [1:0]  ctrl_d, ctrl_q, status_d, status_q;
  logic        irq_q;

  assign wr_s          = dmwr_req_in & (|dmwr_mask_in);
  assign is_ram_s      = (dmaddr_in[31:28] == REGION_RAM);
  assign is_mmio_s     = (dmaddr_in[31:28] == REGION_MMIO);
  assign mmio_off_s    = dmaddr_in[4:2];
  assign unused_addr_s = ^{dmaddr_in[27:ADDR_W+2], dmaddr_in[1:0]};

  // RAM lane enables; held off while reset is asserted so no write lands mid-reset.
  always_comb begin
    ram_be_s = 4'b0000;
    if (wr_s && is_ram_s && rst_in) begin
      ram_be_s = dmwr_mask_in;
    end else begin
      ram_be_s = 4'b0000;
    end
  end

  dmem_ram_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk_i  (clk_in),
    .addr_i (dmaddr_in[ADDR_W+1:2]),
    .wdata_i(dmdata_in),
    .be_i   (ram_be_s),
    .rdata_o(ram_rdata_s)
  );

  // Register next-state: software writes first, then hardware sets so they win over W1C.
  always_comb begin
    gpio_d   = gpio_q;
    ctrl_d   = ctrl_q;
    cmp_d    = cmp_q;
    status_d = status_q;
    if (ctrl_q[CTRL_TIMER_EN]) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
    if (wr_s && is_mmio_s) begin
      case (mmio_off_s)
        OFF_GPIO:  gpio_d  = merge_bytes(gpio_q, dmdata_in, dmwr_mask_in);
        OFF_CTRL:  ctrl_d  = dmwr_mask_in[0] ? dmdata_in[1:0] : ctrl_q;
        OFF_COUNT: count_d = merge_bytes(count_q, dmdata_in, dmwr_mask_in);
        OFF_CMP:   cmp_d   = merge_bytes(cmp_q, dmdata_in, dmwr_mask_in);
        OFF_STATUS: status_d = dmwr_mask_in[0] ? (status_q & ~dmdata_in[1:0]) : status_q;
        default:   gpio_d  = gpio_q;
      endcase
    end else begin
      gpio_d = gpio_q;
    end
    if (ctrl_q[CTRL_TIMER_EN] && (count_q == cmp_q)) begin
      status_d[STATUS_MATCH] = 1'b1;
    end else begin
      status_d[STATUS_MATCH] = status_d[STATUS_MATCH];
    end
    if (wr_s && !is_ram_s && !is_mmio_s) begin
      status_d[STATUS_BUS_ERR] = 1'b1;
    end else begin
      status_d[STATUS_BUS_ERR] = status_d[STATUS_BUS_ERR];
    end
  end

  // MMIO read snapshot of pre-write register values, and the return-path select.
  always_comb begin
    case (mmio_off_s)
      OFF_GPIO:   mmio_rd_s = gpio_q;
      OFF_CTRL:   mmio_rd_s = {30'd0, ctrl_q};
      OFF_COUNT:  mmio_rd_s = count_q;
      OFF_CMP:    mmio_rd_s = cmp_q;
      OFF_STATUS: mmio_rd_s = {30'd0, status_q};
      default:    mmio_rd_s = 32'd0;
    endcase
    if (is_ram_s) begin
      sel_d = SEL_RAM;
    end else if (is_mmio_s) begin
      sel_d = SEL_MMIO;
    end else begin
      sel_d = SEL_NONE;
    end
  end

  // State registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      gpio_q       <= 32'd0;
      ctrl_q       <= 2'b00;
      count_q      <= 32'd0;
      cmp_q        <= CMP_RST;
      status_q     <= 2'b00;
      irq_q        <= 1'b0;
      sel_q        <= SEL_NONE;
      mmio_rdata_q <= 32'd0;
    end else begin
      gpio_q       <= gpio_d;
      ctrl_q       <= ctrl_d;
      count_q      <= count_d;
      cmp_q        <= cmp_d;
      status_q     <= status_d;
      irq_q        <= status_d[STATUS_MATCH] & ctrl_d[CTRL_IRQ_EN];
      sel_q        <= sel_d;
      mmio_rdata_q <= mmio_rd_s;
    end
  end

  // Read-return mux; reset selects SEL_NONE so the output reads 0.
  always_comb begin
    case (sel_q)
      SEL_RAM:  dmdata_out = ram_rdata_s;
      SEL_MMIO: dmdata_out = mmio_rdata_q;
      default:  dmdata_out = 32'd0;
    endcase
  end

  assign gpio_out      = gpio_q;
  assign timer_irq_out = irq_q;
  assign bus_err_out   = status_q[STATUS_BUS_ERR];

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// Directed self-checking bench for dmem_mmio_ctrl.
module tb_dmem_mmio_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] dmaddr_in, dmdata_in;
  logic [3:0]  dmwr_mask_in;
  logic        dmwr_req_in;
  logic [31:0] dmdata_out, gpio_out;
  logic        timer_irq_out, bus_err_out;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] A_GPIO   = 32'h1000_0000;
  localparam logic [31:0] A_CTRL   = 32'h1000_0004;
  localparam logic [31:0] A_COUNT  = 32'h1000_0008;
  localparam logic [31:0] A_CMP    = 32'h1000_000C;
  localparam logic [31:0] A_STATUS = 32'h1000_0010;

  dmem_mmio_ctrl #(.DEPTH_WORDS(1024)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .dmaddr_in    (dmaddr_in),
    .dmdata_in    (dmdata_in),
    .dmwr_mask_in (dmwr_mask_in),
    .dmwr_req_in  (dmwr_req_in),
    .dmdata_out   (dmdata_out),
    .gpio_out     (gpio_out),
    .timer_irq_out(timer_irq_out),
    .bus_err_out  (bus_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic r);
    dmaddr_in    = a;
    dmdata_in    = d;
    dmwr_mask_in = m;
    dmwr_req_in  = r;
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    cyc(a, d, m, 1'b1);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(a, 32'd0, 4'd0, 1'b0);
  endtask

  initial begin
    rst_in = 1'b0;
    dmaddr_in = 32'd0; dmdata_in = 32'd0; dmwr_mask_in = 4'd0; dmwr_req_in = 1'b0;
    #12;
    chk("rst_dmdata", dmdata_out, 32'd0);
    chk("rst_gpio", gpio_out, 32'd0);
    chk("rst_irq", {31'd0, timer_irq_out}, 32'd0);
    chk("rst_buserr", {31'd0, bus_err_out}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;

    rd(A_CMP);    chk("rst_cmp", dmdata_out, 32'hFFFF_FFFF);
    rd(A_COUNT);  chk("rst_count", dmdata_out, 32'd0);
    rd(A_STATUS); chk("rst_status", dmdata_out, 32'd0);

    // RAM byte-lane writes, read-first
    wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    wr(32'h0000_0010, 32'h0000_5500, 4'b0010); chk("ram_rf_old", dmdata_out, 32'hDEAD_BEEF);
    rd(32'h0000_0010);                          chk("ram_lane", dmdata_out, 32'hDEAD_55EF);
    cyc(32'h0000_0010, 32'h0, 4'h0, 1'b1);
    rd(32'h0000_0010);                          chk("ram_mask0", dmdata_out, 32'hDEAD_55EF);
    wr(32'h0000_0020, 32'h1, 4'hF);
    wr(32'h0000_0020, 32'h2, 4'hF);             chk("ram_rdw", dmdata_out, 32'h1);
    rd(32'h0000_0020);                          chk("ram_new", dmdata_out, 32'h2);
    rd(32'h0000_1020);                          chk("ram_alias", dmdata_out, 32'h2);

    // GPIO and CTRL
    wr(A_GPIO, 32'h1234_5678, 4'hF);            chk("gpio_full", gpio_out, 32'h1234_5678);
    wr(A_GPIO, 32'hAABB_CCDD, 4'b0100);         chk("gpio_lane", gpio_out, 32'h12BB_5678);
    rd(A_GPIO);                                 chk("gpio_rd", dmdata_out, 32'h12BB_5678);
    wr(A_CTRL, 32'hFFFF_FFF0, 4'hF);
    rd(A_CTRL);                                 chk("ctrl_rsvd", dmdata_out, 32'd0);
    wr(32'h1000_0014, 32'hFFFF_FFFF, 4'hF);
    rd(32'h1000_0014);                          chk("off5_zero", dmdata_out, 32'd0);

    // Timer compare and interrupt
    wr(A_CMP, 32'd5, 4'hF);
    wr(A_CTRL, 32'd3, 4'hF);
    for (int i = 0; i < 5; i++) rd(32'd0);
    chk("irq_before", {31'd0, timer_irq_out}, 32'd0);
    rd(32'd0);                                  chk("irq_rise", {31'd0, timer_irq_out}, 32'd1);
    rd(A_STATUS);                               chk("status_match", dmdata_out, 32'd1);
    wr(A_STATUS, 32'd1, 4'b0001);               chk("irq_w1c", {31'd0, timer_irq_out}, 32'd0);
    wr(A_CTRL, 32'd0, 4'hF);
    rd(A_COUNT);                                chk("count_stop", dmdata_out, 32'd9);

    // Wrap and software override
    wr(A_COUNT, 32'hFFFF_FFFF, 4'hF);
    wr(A_CTRL, 32'd1, 4'hF);
    rd(A_COUNT);                                chk("count_max", dmdata_out, 32'hFFFF_FFFF);
    rd(A_COUNT);                                chk("count_wrap", dmdata_out, 32'd0);
    wr(A_COUNT, 32'd100, 4'hF);
    rd(A_COUNT);                                chk("count_ovr", dmdata_out, 32'd100);
    rd(A_COUNT);                                chk("count_ovr1", dmdata_out, 32'd101);
    wr(A_CTRL, 32'd0, 4'hF);

    // Match set coincident with W1C keeps the flag
    wr(A_COUNT, 32'd10, 4'hF);
    wr(A_CMP, 32'd12, 4'hF);
    wr(A_CTRL, 32'd1, 4'hF);
    rd(32'd0);
    rd(32'd0);
    wr(A_STATUS, 32'd1, 4'b0001);
    rd(A_STATUS);                               chk("match_wins", dmdata_out, 32'd1);
    wr(A_CTRL, 32'd0, 4'hF);
    wr(A_STATUS, 32'd3, 4'b0001);
    rd(A_STATUS);                               chk("status_clr", dmdata_out, 32'd0);

    // Unmapped accesses
    wr(32'h2000_0000, 32'h1111_1111, 4'hF);     chk("buserr_set", {31'd0, bus_err_out}, 32'd1);
    rd(32'h2000_0000);                          chk("unmap_rd0", dmdata_out, 32'd0);
    rd(32'h3000_0000);                          chk("buserr_rdonly", {31'd0, bus_err_out}, 32'd1);
    wr(A_STATUS, 32'h0000_0202, 4'b0010);       chk("w1c_lane1", {31'd0, bus_err_out}, 32'd1);
    wr(A_STATUS, 32'd2, 4'b0001);               chk("w1c_buserr", {31'd0, bus_err_out}, 32'd0);
    cyc(32'h2000_0000, 32'hFFFF_FFFF, 4'h0, 1'b1);
    chk("buserr_mask0", {31'd0, bus_err_out}, 32'd0);
    wr(32'h3000_0004, 32'd1, 4'b1000);          chk("buserr_again", {31'd0, bus_err_out}, 32'd1);

    // Build up state, then reset mid-write
    wr(32'h0000_0040, 32'hCAFE_F00D, 4'hF);
    wr(A_COUNT, 32'h50, 4'hF);
    wr(A_CMP, 32'h50, 4'hF);
    wr(A_CTRL, 32'd3, 4'hF);
    rd(32'd0);                                  chk("pre_rst_irq", {31'd0, timer_irq_out}, 32'd1);
    dmaddr_in = 32'h0000_0040; dmdata_in = 32'd0; dmwr_mask_in = 4'hF; dmwr_req_in = 1'b1;
    #2;
    rst_in = 1'b0;
    #1;
    chk("mid_rst_gpio", gpio_out, 32'd0);
    chk("mid_rst_irq", {31'd0, timer_irq_out}, 32'd0);
    chk("mid_rst_buserr", {31'd0, bus_err_out}, 32'd0);
    chk("mid_rst_dmdata", dmdata_out, 32'd0);
    @(posedge clk_in);
    #1;
    chk("rst_hold_dmdata", dmdata_out, 32'd0);
    @(negedge clk_in);
    dmwr_req_in = 1'b0; dmwr_mask_in = 4'h0;
    rst_in = 1'b1;
    rd(32'h0000_0040);                          chk("ram_kept", dmdata_out, 32'hCAFE_F00D);
    rd(A_CMP);                                  chk("post_cmp", dmdata_out, 32'hFFFF_FFFF);
    rd(A_CTRL);                                 chk("post_ctrl", dmdata_out, 32'd0);
    rd(A_COUNT);                                chk("post_count", dmdata_out, 32'd0);
    rd(A_STATUS);                               chk("post_status", dmdata_out, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
